// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the bus-computer control sequencer: control-word bit
// indices, opcodes and micro-step encodings.
package cpu_ctrl_pkg;

    typedef logic [15:0] ctrl_word_t;

    localparam int CO = 0;
    localparam int MI = 1;
    localparam int RO = 2;
    localparam int RI = 3;
    localparam int II = 4;
    localparam int IO = 5;
    localparam int AI = 6;
    localparam int AO = 7;
    localparam int EO = 8;
    localparam int SU = 9;
    localparam int BI = 10;
    localparam int OI = 11;
    localparam int CE = 12;
    localparam int J  = 13;
    localparam int FI = 14;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int STEP_W = $clog2(5);

    localparam logic [STEP_W-1:0] T0 = 3'd0;
    localparam logic [STEP_W-1:0] T1 = 3'd1;
    localparam logic [STEP_W-1:0] T2 = 3'd2;
    localparam logic [STEP_W-1:0] T3 = 3'd3;
    localparam logic [STEP_W-1:0] T4 = 3'd4;

endpackage

// File: rtl/control_sequencer_if.sv
// Bundle between the control sequencer and the rest of the machine: run,
// instruction/flag inputs, and the control word plus debug state outputs.
interface control_sequencer_if;
    import cpu_ctrl_pkg::*;

    logic              run;
    logic [3:0]        opcode;
    logic              flag_c;
    logic              flag_z;
    ctrl_word_t        ctrl;
    logic [STEP_W-1:0] step;
    logic              halted;

    modport master (output run, opcode, flag_c, flag_z, input ctrl, step, halted);
    modport slave  (input run, opcode, flag_c, flag_z, output ctrl, step, halted);

endinterface

// File: rtl/microcode_rom.sv
// Combinational microcode: {opcode, step, flags} -> control word.
// Steps outside T0..T4 decode to an empty word.
module microcode_rom
    import cpu_ctrl_pkg::*;
(
    input  logic [3:0]        opcode,
    input  logic [STEP_W-1:0] step,
    input  logic              flag_c,
    input  logic              flag_z,
    output ctrl_word_t        word
);

    always_comb begin
        word = '0;
        if (step == T0) begin
            word[CO] = 1'b1;
            word[MI] = 1'b1;
        end else if (step == T1) begin
            word[RO] = 1'b1;
            word[II] = 1'b1;
            word[CE] = 1'b1;
        end else begin
            case (opcode)
                OP_LDA: begin
                    if (step == T2) begin word[IO] = 1'b1; word[MI] = 1'b1; end
                    if (step == T3) begin word[RO] = 1'b1; word[AI] = 1'b1; end
                end
                OP_ADD, OP_SUB: begin
                    if (step == T2) begin word[IO] = 1'b1; word[MI] = 1'b1; end
                    if (step == T3) begin word[RO] = 1'b1; word[BI] = 1'b1; end
                    if (step == T4) begin
                        word[EO] = 1'b1;
                        word[AI] = 1'b1;
                        word[FI] = 1'b1;
                        word[SU] = (opcode == OP_SUB);
                    end
                end
                OP_STA: begin
                    if (step == T2) begin word[IO] = 1'b1; word[MI] = 1'b1; end
                    if (step == T3) begin word[AO] = 1'b1; word[RI] = 1'b1; end
                end
                OP_LDI: if (step == T2) begin word[IO] = 1'b1; word[AI] = 1'b1; end
                OP_JMP: if (step == T2) begin word[IO] = 1'b1; word[J] = 1'b1; end
                OP_JC:  if (step == T2 && flag_c) begin word[IO] = 1'b1; word[J] = 1'b1; end
                OP_JZ:  if (step == T2 && flag_z) begin word[IO] = 1'b1; word[J] = 1'b1; end
                OP_OUT: if (step == T2) begin word[AO] = 1'b1; word[OI] = 1'b1; end
                OP_NOP, OP_HLT: ;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Micro-step counter with early termination, sticky halt, and run/halt gating
// of the decoded control word.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int STEPS = 5
) (
    input logic                 clk,
    input logic                 clr,
    control_sequencer_if.slave  bus
);

    localparam logic [STEP_W-1:0] LAST = STEP_W'(STEPS - 1);

    logic [STEP_W-1:0] step_q;
    logic [STEP_W-1:0] step_inc;
    logic              halted_q;
    logic              active;
    ctrl_word_t        word_cur;
    ctrl_word_t        word_nxt;

    assign step_inc = step_q + STEP_W'(1);
    assign active   = bus.run & ~halted_q;

    microcode_rom u_rom_cur (
        .opcode (bus.opcode),
        .step   (step_q),
        .flag_c (bus.flag_c),
        .flag_z (bus.flag_z),
        .word   (word_cur)
    );

    // Looks one step ahead so an instruction ends as soon as its remaining
    // micro-steps would be empty.
    microcode_rom u_rom_nxt (
        .opcode (bus.opcode),
        .step   (step_inc),
        .flag_c (bus.flag_c),
        .flag_z (bus.flag_z),
        .word   (word_nxt)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            step_q   <= T0;
            halted_q <= 1'b0;
        end else if (active) begin
            if (step_q == T2 && bus.opcode == OP_HLT) begin
                halted_q <= 1'b1;
                step_q   <= T0;
            end else if (step_q == LAST || (step_q >= T2 && word_nxt == '0)) begin
                step_q <= T0;
            end else begin
                step_q <= step_inc;
            end
        end
    end

    assign bus.ctrl   = active ? word_cur : '0;
    assign bus.step   = step_q;
    assign bus.halted = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed scenarios plus a random
// soak against an instruction-level reference model.
module tb_control_sequencer;
    import cpu_ctrl_pkg::*;

    logic clk = 1'b0;
    logic clr = 1'b1;
    int   checks = 0;
    int   failures = 0;

    control_sequencer_if bus();

    control_sequencer #(.STEPS(5)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Execute-phase words per opcode, index 0 = T2.
    function automatic logic [15:0] exec_word(logic [3:0] op, int idx, logic fc, logic fz);
        logic [15:0] w [3];
        w = '{16'h0000, 16'h0000, 16'h0000};
        case (op)
            4'h1: w = '{16'h0022, 16'h0044, 16'h0000};
            4'h2: w = '{16'h0022, 16'h0404, 16'h4140};
            4'h3: w = '{16'h0022, 16'h0404, 16'h4340};
            4'h4: w = '{16'h0022, 16'h0088, 16'h0000};
            4'h5: w[0] = 16'h0060;
            4'h6: w[0] = 16'h2020;
            4'h7: if (fc) w[0] = 16'h2020;
            4'h8: if (fz) w[0] = 16'h2020;
            4'hE: w[0] = 16'h0880;
            default: ;
        endcase
        if (idx < 0 || idx > 2) return 16'h0000;
        return w[idx];
    endfunction

    function automatic logic [15:0] exp_ctrl(logic [3:0] op, int s, logic fc, logic fz);
        if (s == 0) return 16'h0003;
        if (s == 1) return 16'h1014;
        return exec_word(op, s - 2, fc, fz);
    endfunction

    function automatic int instr_len(logic [3:0] op, logic fc, logic fz);
        int n = 0;
        for (int i = 0; i < 3; i++) if (exec_word(op, i, fc, fz) != 16'h0000) n++;
        return 2 + ((n == 0) ? 1 : n);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.run = 1'b1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        bus.run = 1'b1; bus.opcode = 4'h0; bus.flag_c = 1'b0; bus.flag_z = 1'b0;
        clr = 1'b1;
        tick();
        checks++; if (bus.step !== 3'd0) begin failures++; $display("FAIL reset_step got=%0d exp=0", bus.step); end
        checks++; if (bus.halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", bus.halted); end
        checks++; if (bus.ctrl !== 16'h0003) begin failures++; $display("FAIL reset_ctrl_run got=%h exp=0003", bus.ctrl); end
        bus.run = 1'b0; #1;
        checks++; if (bus.ctrl !== 16'h0000) begin failures++; $display("FAIL reset_ctrl_norun got=%h exp=0000", bus.ctrl); end
        bus.run = 1'b1;
        tick();
        checks++; if (bus.step !== 3'd0) begin failures++; $display("FAIL reset_hold_step got=%0d exp=0", bus.step); end
    endtask

    task automatic test_nop();
        logic [3:0]  ops [3];
        logic [15:0] ec  [4];
        int          es  [4];
        ops = '{4'h0, 4'h9, 4'hD};
        ec  = '{16'h0003, 16'h1014, 16'h0000, 16'h0003};
        es  = '{0, 1, 2, 0};
        for (int k = 0; k < 3; k++) begin
            bus.opcode = ops[k];
            do_reset();
            for (int i = 0; i < 4; i++) begin
                checks++; if (bus.step !== 3'(es[i])) begin failures++; $display("FAIL nop_step op=%h i=%0d got=%0d exp=%0d", ops[k], i, bus.step, es[i]); end
                checks++; if (bus.ctrl !== ec[i]) begin failures++; $display("FAIL nop_ctrl op=%h i=%0d got=%h exp=%h", ops[k], i, bus.ctrl, ec[i]); end
                if (i < 3) tick();
            end
        end
    endtask

    task automatic test_add_sub();
        logic [15:0] ec [6];
        for (int k = 0; k < 2; k++) begin
            ec = '{16'h0003, 16'h1014, 16'h0022, 16'h0404, 16'h4140, 16'h0003};
            if (k == 1) ec[4] = 16'h4340;
            bus.opcode = (k == 0) ? 4'h2 : 4'h3;
            do_reset();
            for (int i = 0; i < 6; i++) begin
                checks++; if (bus.step !== 3'((i == 5) ? 0 : i)) begin failures++; $display("FAIL addsub_step k=%0d i=%0d got=%0d", k, i, bus.step); end
                checks++; if (bus.ctrl !== ec[i]) begin failures++; $display("FAIL addsub_ctrl k=%0d i=%0d got=%h exp=%h", k, i, bus.ctrl, ec[i]); end
                if (i < 5) tick();
            end
        end
    endtask

    task automatic test_exec_all();
        logic fc, fz;
        int   len;
        logic [15:0] e;
        for (int op = 0; op < 15; op++) begin
            fc = 1'($urandom % 2); fz = 1'($urandom % 2);
            bus.opcode = 4'(op); bus.flag_c = fc; bus.flag_z = fz;
            do_reset();
            len = instr_len(4'(op), fc, fz);
            for (int s = 0; s < len; s++) begin
                e = exp_ctrl(4'(op), s, fc, fz);
                checks++; if (bus.step !== 3'(s)) begin failures++; $display("FAIL exec_step op=%h s=%0d got=%0d", op, s, bus.step); end
                checks++; if (bus.ctrl !== e) begin failures++; $display("FAIL exec_ctrl op=%h s=%0d got=%h exp=%h", op, s, bus.ctrl, e); end
                tick();
            end
            checks++; if (bus.step !== 3'd0) begin failures++; $display("FAIL exec_end op=%h got=%0d exp=0", op, bus.step); end
        end
    endtask

    task automatic test_jump();
        logic [3:0]  ops [6];
        logic        fcs [6];
        logic        fzs [6];
        logic [15:0] ex  [6];
        ops = '{4'h7, 4'h7, 4'h7, 4'h8, 4'h8, 4'h8};
        fcs = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        fzs = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        ex  = '{16'h2020, 16'h0000, 16'h0000, 16'h2020, 16'h0000, 16'h0000};
        for (int k = 0; k < 6; k++) begin
            bus.opcode = ops[k]; bus.flag_c = fcs[k]; bus.flag_z = fzs[k];
            do_reset();
            tick(); tick();
            checks++; if (bus.ctrl !== ex[k]) begin failures++; $display("FAIL jump_t2 k=%0d got=%h exp=%h", k, bus.ctrl, ex[k]); end
            tick();
            checks++; if (bus.step !== 3'd0) begin failures++; $display("FAIL jump_next k=%0d got=%0d exp=0", k, bus.step); end
        end
    endtask

    task automatic test_halt();
        bus.opcode = 4'hF;
        do_reset();
        tick(); tick();
        checks++; if (bus.halted !== 1'b0 || bus.step !== 3'd2 || bus.ctrl !== 16'h0) begin
            failures++; $display("FAIL halt_t2 halted=%b step=%0d ctrl=%h exp=0/2/0000", bus.halted, bus.step, bus.ctrl); end
        tick();
        for (int i = 0; i < 20; i++) begin
            checks++; if (bus.halted !== 1'b1 || bus.step !== 3'd0 || bus.ctrl !== 16'h0) begin
                failures++; $display("FAIL halt_hold i=%0d halted=%b step=%0d ctrl=%h exp=1/0/0000", i, bus.halted, bus.step, bus.ctrl); end
            bus.run = 1'($urandom % 2);
            bus.opcode = 4'($urandom % 16);
            tick();
        end
        bus.run = 1'b1;
        #2 clr = 1'b1;
        #1;
        checks++; if (bus.halted !== 1'b0) begin failures++; $display("FAIL halt_clr_halted got=%b exp=0", bus.halted); end
        checks++; if (bus.ctrl !== 16'h0003) begin failures++; $display("FAIL halt_clr_ctrl got=%h exp=0003", bus.ctrl); end
        clr = 1'b0;
    endtask

    task automatic test_pause();
        bus.opcode = 4'h1;
        do_reset();
        tick(); tick(); tick();
        checks++; if (bus.step !== 3'd3 || bus.ctrl !== 16'h0044) begin
            failures++; $display("FAIL pause_pre step=%0d ctrl=%h exp=3/0044", bus.step, bus.ctrl); end
        bus.run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.step !== 3'd3 || bus.ctrl !== 16'h0) begin
                failures++; $display("FAIL pause_hold i=%0d step=%0d ctrl=%h exp=3/0000", i, bus.step, bus.ctrl); end
            tick();
        end
        bus.run = 1'b1; #1;
        checks++; if (bus.step !== 3'd3 || bus.ctrl !== 16'h0044) begin
            failures++; $display("FAIL pause_resume step=%0d ctrl=%h exp=3/0044", bus.step, bus.ctrl); end
        tick();
        checks++; if (bus.step !== 3'd0 || bus.ctrl !== 16'h0003) begin
            failures++; $display("FAIL pause_once step=%0d ctrl=%h exp=0/0003", bus.step, bus.ctrl); end
    endtask

    task automatic test_async_clr();
        bus.opcode = 4'h4;
        do_reset();
        tick(); tick(); tick();
        checks++; if (bus.ctrl !== 16'h0088) begin failures++; $display("FAIL aclr_sta_t3 got=%h exp=0088", bus.ctrl); end
        #2 clr = 1'b1;
        #1;
        checks++; if (bus.step !== 3'd0 || bus.ctrl !== 16'h0003) begin
            failures++; $display("FAIL aclr_now step=%0d ctrl=%h exp=0/0003", bus.step, bus.ctrl); end
        #1 clr = 1'b0;
        tick();
        checks++; if (bus.step !== 3'd1 || bus.ctrl !== 16'h1014) begin
            failures++; $display("FAIL aclr_restart step=%0d ctrl=%h exp=1/1014", bus.step, bus.ctrl); end
    endtask

    task automatic test_soak();
        int          ms = 0;
        logic        mh = 1'b0;
        logic [3:0]  op = 4'h0;
        logic        rn, fc, fz;
        logic [15:0] ec;
        bus.opcode = 4'h0;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            if (mh && ($urandom % 8 == 0)) begin
                clr = 1'b1; #1; clr = 1'b0;
                ms = 0; mh = 1'b0;
            end
            if (ms == 0) op = 4'($urandom % 16);
            rn = (($urandom % 4) != 0);
            fc = 1'($urandom % 2);
            fz = 1'($urandom % 2);
            bus.opcode = op; bus.run = rn; bus.flag_c = fc; bus.flag_z = fz;
            #1;
            ec = (rn && !mh) ? exp_ctrl(op, ms, fc, fz) : 16'h0000;
            checks++; if (bus.step !== 3'(ms)) begin failures++; $display("FAIL soak_step c=%0d op=%h got=%0d exp=%0d", c, op, bus.step, ms); end
            checks++; if (bus.halted !== mh) begin failures++; $display("FAIL soak_halted c=%0d got=%b exp=%b", c, bus.halted, mh); end
            checks++; if (bus.ctrl !== ec) begin failures++; $display("FAIL soak_ctrl c=%0d op=%h s=%0d got=%h exp=%h", c, op, ms, bus.ctrl, ec); end
            checks++; if ($countones(bus.ctrl & 16'h01A5) > 1) begin failures++; $display("FAIL soak_bus_excl c=%0d got=%h exp=<=1 driver", c, bus.ctrl); end
            if (rn && !mh) begin
                if (op == 4'hF && ms == 2) begin
                    mh = 1'b1; ms = 0;
                end else begin
                    ms = (ms + 1 >= instr_len(op, fc, fz)) ? 0 : ms + 1;
                end
            end
            tick();
        end
    endtask

    initial begin
        bus.run = 1'b0; bus.opcode = 4'h0; bus.flag_c = 1'b0; bus.flag_z = 1'b0;
        test_reset();
        test_nop();
        test_add_sub();
        test_exec_all();
        test_jump();
        test_halt();
        test_pause();
        test_async_clr();
        test_soak();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
